// File: rtl/ps2_device_emulator.sv
// PS/2 device end: generates PS2_CLK, sends bytes to the host and receives host
// commands with line ACK. Both lines are open-drain and sampled through 2-flop syncs.
module ps2_device_emulator #(
  parameter int HALF_PERIOD = 2000,
  parameter int INHIBIT_MIN = 5000,
  parameter int HOLDOFF     = 2500
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);
  // state | meaning
  // IDLE  | lines released; watch for host inhibit, or start a pending byte after holdoff
  // HOLD  | one-cycle setup of a device->host frame
  // TX    | shifting start, d0..d7, parity, stop out; host clk-low aborts until stop
  // RX    | generating 10 clocks, sampling d0..d7, parity, stop in the high phases
  // ACK   | driving DAT low for one extra clock, then releasing both lines
  // INHIB | host holds clk low; on release go RX if DAT low, else back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_TX, S_RX, S_ACK, S_INHIB} state_t;

  localparam int TMAX = (INHIBIT_MIN > HOLDOFF)
                        ? ((INHIBIT_MIN > HALF_PERIOD) ? INHIBIT_MIN : HALF_PERIOD)
                        : ((HOLDOFF > HALF_PERIOD) ? HOLDOFF : HALF_PERIOD);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_HALF   = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_SAMPLE = TW'(HALF_PERIOD - 8);
  localparam logic [TW-1:0] T_CHECK  = TW'(HALF_PERIOD - 9);
  localparam logic [TW-1:0] T_INHIB  = TW'(INHIBIT_MIN - 1);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLDOFF);

  state_t        state;
  logic          clk_m, clk_s, dat_m, dat_s;
  logic          clk_oe, dat_oe, low_ph, rx_pend;
  logic [TW-1:0] timer, idle_tmr, low_tmr;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_byte;
  logic [9:0]    rx_shift;
  logic [10:0]   frame;

  assign frame   = {1'b1, ~^tx_byte, tx_byte, 1'b0};
  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_m <= 1'b1; clk_s <= 1'b1; dat_m <= 1'b1; dat_s <= 1'b1;
      state <= S_IDLE; clk_oe <= 1'b0; dat_oe <= 1'b0; low_ph <= 1'b0;
      timer <= '0; idle_tmr <= T_HOLD; low_tmr <= T_INHIB; bit_cnt <= '0;
      tx_byte <= '0; tx_ready <= 1'b1; rx_shift <= '0; rx_pend <= 1'b0;
      rx_data <= '0; rx_valid <= 1'b0; rx_parity_err <= 1'b0;
    end else begin
      clk_m <= PS2_CLK; clk_s <= clk_m;
      dat_m <= PS2_DAT; dat_s <= dat_m;
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      if (rx_pend) begin
        rx_data       <= rx_shift[7:0];
        rx_parity_err <= ~rx_shift[9] | ~(^rx_shift[8:0]);
      end
      if (tx_valid && tx_ready) begin
        tx_byte  <= tx_data;
        tx_ready <= 1'b0;
      end
      idle_tmr <= T_HOLD;
      low_tmr  <= T_INHIB;
      timer    <= (timer != '0) ? timer - 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (!clk_s) begin
            low_tmr <= (low_tmr != '0) ? low_tmr - 1'b1 : '0;
            if (low_tmr == '0) state <= S_INHIB;
          end else if (dat_s) begin
            idle_tmr <= (idle_tmr != '0) ? idle_tmr - 1'b1 : '0;
            if (!tx_ready && idle_tmr == '0) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          dat_oe <= 1'b1; clk_oe <= 1'b0; low_ph <= 1'b0;
          bit_cnt <= '0; timer <= T_HALF; state <= S_TX;
        end
        S_TX: begin
          if (!low_ph) begin
            // the host can still take the bus back up to the parity bit
            if (bit_cnt != 4'd10 && timer <= T_CHECK && !clk_s) begin
              clk_oe <= 1'b0; dat_oe <= 1'b0; state <= S_INHIB;
            end else if (timer == '0) begin
              clk_oe <= 1'b1; low_ph <= 1'b1; timer <= T_HALF;
            end
          end else if (timer == '0) begin
            if (bit_cnt == 4'd10) begin
              clk_oe <= 1'b0; dat_oe <= 1'b0; tx_ready <= 1'b1; state <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1; dat_oe <= ~frame[bit_cnt + 4'd1];
              clk_oe <= 1'b0; low_ph <= 1'b0; timer <= T_HALF;
            end
          end
        end
        S_RX: begin
          if (low_ph) begin
            if (timer == '0) begin
              clk_oe <= 1'b0; low_ph <= 1'b0; timer <= T_HALF;
            end
          end else begin
            if (timer == T_SAMPLE) rx_shift <= {dat_s, rx_shift[9:1]};
            if (timer <= T_CHECK && !clk_s) begin
              clk_oe <= 1'b0; dat_oe <= 1'b0; state <= S_INHIB;
            end else if (timer == '0) begin
              if (bit_cnt == 4'd9) begin
                if (rx_shift[9]) begin
                  dat_oe <= 1'b1; timer <= T_HALF; state <= S_ACK;
                end else begin
                  rx_pend <= 1'b1; state <= S_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1; clk_oe <= 1'b1; low_ph <= 1'b1; timer <= T_HALF;
              end
            end
          end
        end
        S_ACK: begin
          if (timer == '0) begin
            if (!low_ph) begin
              clk_oe <= 1'b1; low_ph <= 1'b1; timer <= T_HALF;
            end else begin
              clk_oe <= 1'b0; dat_oe <= 1'b0; rx_pend <= 1'b1; state <= S_IDLE;
            end
          end
        end
        S_INHIB: begin
          clk_oe <= 1'b0; dat_oe <= 1'b0;
          if (clk_s) begin
            if (!dat_s) begin
              clk_oe <= 1'b1; low_ph <= 1'b1; bit_cnt <= '0; timer <= T_HALF; state <= S_RX;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_emulator.sv
// Bench for ps2_device_emulator: a PS/2 host model drives/decodes frames on pulled-up
// open-drain lines; expected frames and parity come from the bit-level protocol rules.
module tb_ps2_device_emulator;
  localparam int HP = 16, INH = 64, HOLD = 24, BUDGET = 2000;

  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, rx_valid, rx_parity_err, busy;
  logic [7:0] rx_data;
  wire PS2_CLK, PS2_DAT;
  logic h_clk_low = 1'b0, h_dat_low = 1'b0;
  int n_tests = 0, n_fail = 0;

  assign PS2_CLK = h_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = h_dat_low ? 1'b0 : 1'bz;
  pullup (PS2_CLK);
  pullup (PS2_DAT);

  ps2_device_emulator #(.HALF_PERIOD(HP), .INHIBIT_MIN(INH), .HOLDOFF(HOLD)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .busy(busy), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT));

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  // Frame a device->host byte should produce, bit 0 first on the wire.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic wait_fall(input int budget, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = PS2_CLK;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (prev === 1'b1 && PS2_CLK === 1'b0) ok = 1'b1;
      prev = PS2_CLK;
    end
  endtask

  task automatic wait_rise(input int budget, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = PS2_CLK;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (prev === 1'b0 && PS2_CLK === 1'b1) ok = 1'b1;
      prev = PS2_CLK;
    end
  endtask

  task automatic host_receive(input int nfalls, output logic [10:0] bits, output bit ok);
    bits = '0;
    ok = 1'b1;
    for (int i = 0; i < nfalls && ok; i++) begin
      wait_fall(BUDGET, ok);
      bits[i] = PS2_DAT;
    end
  endtask

  // Host request-to-send followed by d0..d7, parity, stop on the device's clocks.
  task automatic host_send(input logic [7:0] b, input logic par, input logic stop,
                           output bit ok, output bit ack, output bit got,
                           output logic [7:0] data, output logic err, output bit one_cycle);
    logic [9:0] f;
    f = {stop, par, b};
    ok = 1'b1; ack = 1'b0; got = 1'b0; data = '0; err = 1'b0; one_cycle = 1'b0;
    h_clk_low = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (INH + 10) tick();
    h_dat_low = 1'b1;
    repeat (5) tick();
    h_clk_low = 1'b0;
    tick();
    for (int i = 0; i < 10 && ok; i++) begin
      wait_fall(BUDGET, ok);
      h_dat_low = ~f[i];
    end
    for (int c = 0; c < BUDGET && ok && !got; c++) begin
      tick();
      if (!h_dat_low && PS2_DAT === 1'b0) ack = 1'b1;
      if (rx_valid === 1'b1) begin
        got = 1'b1; data = rx_data; err = rx_parity_err;
      end
    end
    tick();
    one_cycle = (rx_valid === 1'b0);
    h_dat_low = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_tests++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", rx_parity_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (PS2_CLK !== 1'b1 || PS2_DAT !== 1'b1) begin n_fail++; $display("FAIL reset_lines: got clk=%b dat=%b expected 1 1", PS2_CLK, PS2_DAT); end
    reset = 1'b0;
    repeat (HOLD + 4) tick();
  endtask

  task automatic test_rx_f4();
    bit ok, ack, got, one; logic [7:0] d; logic e;
    host_send(8'hF4, 1'b0, 1'b1, ok, ack, got, d, e, one);
    n_tests++; if (!(ok && got)) begin n_fail++; $display("FAIL rx_f4_done: got ok=%b valid=%b expected 1 1", ok, got); end
    n_tests++; if (d !== 8'hF4) begin n_fail++; $display("FAIL rx_f4_data: got %h expected f4", d); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL rx_f4_parity_err: got %b expected 0", e); end
    n_tests++; if (!ack) begin n_fail++; $display("FAIL rx_f4_ack: got %b expected 1", ack); end
    n_tests++; if (!one) begin n_fail++; $display("FAIL rx_f4_pulse_width: got %b expected 1", one); end
  endtask

  task automatic test_tx_fa();
    logic [10:0] bits; bit ok;
    tx_data = 8'hFA; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_fa_accept: got tx_ready=%b expected 0", tx_ready); end
    host_receive(11, bits, ok);
    n_tests++; if (!ok || bits !== 11'b11_1111_1010_0) begin n_fail++; $display("FAIL tx_fa_frame: got ok=%b bits=%b expected 11111110100", ok, bits); end
    repeat (HP + 3) tick();
    n_tests++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tx_fa_done: got ready=%b busy=%b expected 1 0", tx_ready, busy); end
  endtask

  task automatic test_rx_parity_err();
    bit ok, ack, got, one; logic [7:0] d; logic e;
    host_send(8'h00, 1'b0, 1'b1, ok, ack, got, d, e, one);
    n_tests++; if (!(ok && got) || d !== 8'h00) begin n_fail++; $display("FAIL rx_perr_data: got ok=%b valid=%b data=%h expected 1 1 00", ok, got, d); end
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL rx_perr_flag: got %b expected 1", e); end
  endtask

  task automatic test_bad_stop();
    bit ok, ack, got, one; logic [7:0] d; logic e;
    host_send(8'h3C, 1'b1, 1'b0, ok, ack, got, d, e, one);
    n_tests++; if (!(ok && got) || d !== 8'h3C) begin n_fail++; $display("FAIL rx_stop0_data: got ok=%b valid=%b data=%h expected 1 1 3c", ok, got, d); end
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL rx_stop0_flag: got %b expected 1", e); end
  endtask

  task automatic test_abort();
    logic [10:0] bits; bit ok;
    tx_data = 8'hAA; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    host_receive(4, bits, ok);
    if (ok) wait_rise(BUDGET, ok);
    repeat (3) tick();
    h_clk_low = 1'b1;
    repeat (40) tick();
    n_tests++; if (!ok || busy !== 1'b1 || tx_ready !== 1'b0) begin n_fail++; $display("FAIL abort_state: got ok=%b busy=%b ready=%b expected 1 1 0", ok, busy, tx_ready); end
    n_tests++; if (PS2_DAT !== 1'b1) begin n_fail++; $display("FAIL abort_dat_released: got %b expected 1", PS2_DAT); end
    h_clk_low = 1'b0;
    host_receive(11, bits, ok);
    n_tests++; if (!ok || bits !== exp_frame(8'hAA)) begin n_fail++; $display("FAIL abort_resend: got ok=%b bits=%b expected %b", ok, bits, exp_frame(8'hAA)); end
    repeat (HP + 3) tick();
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_priority();
    bit ok, ack, got, one; logic [7:0] d; logic e; logic [10:0] bits;
    tx_data = 8'h55; tx_valid = 1'b1;
    host_send(8'h41, 1'b1, 1'b1, ok, ack, got, d, e, one);
    n_tests++; if (!(ok && got) || d !== 8'h41 || e !== 1'b0) begin n_fail++; $display("FAIL prio_rx: got ok=%b valid=%b data=%h err=%b expected 1 1 41 0", ok, got, d, e); end
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL prio_pending: got tx_ready=%b expected 0", tx_ready); end
    host_receive(11, bits, ok);
    n_tests++; if (!ok || bits !== exp_frame(8'h55)) begin n_fail++; $display("FAIL prio_tx: got ok=%b bits=%b expected %b", ok, bits, exp_frame(8'h55)); end
    repeat (HP + 3) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, c; logic [10:0] bits; bit ok;
    a = 8'($urandom); c = 8'($urandom);
    tx_data = a; tx_valid = 1'b1;
    tick();
    tx_data = ~a;
    tick();
    tx_valid = 1'b0;
    host_receive(11, bits, ok);
    n_tests++; if (!ok || bits !== exp_frame(a)) begin n_fail++; $display("FAIL b2b_first: got ok=%b bits=%b expected %b", ok, bits, exp_frame(a)); end
    ok = 1'b0;
    for (int k = 0; k < BUDGET && !ok; k++) begin
      tick();
      if (tx_ready === 1'b1) ok = 1'b1;
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_ready: got tx_ready=%b expected 1", tx_ready); end
    tx_data = c; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    host_receive(11, bits, ok);
    n_tests++; if (!ok || bits !== exp_frame(c)) begin n_fail++; $display("FAIL b2b_second: got ok=%b bits=%b expected %b", ok, bits, exp_frame(c)); end
    repeat (HP + 3) tick();
  endtask

  task automatic test_random();
    bit ok, ack, got, one; logic [7:0] b, d; logic e, p, exp_err; logic [10:0] bits;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom); p = 1'($urandom_range(0, 1));
      exp_err = ($countones({p, b}) % 2 == 0);
      host_send(b, p, 1'b1, ok, ack, got, d, e, one);
      n_tests++; if (!(ok && got && ack) || d !== b || e !== exp_err) begin n_fail++; $display("FAIL rand_rx: got ok=%b valid=%b ack=%b data=%h err=%b expected 1 1 1 %h %b", ok, got, ack, d, e, b, exp_err); end
      b = 8'($urandom);
      tx_data = b; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      host_receive(11, bits, ok);
      n_tests++; if (!ok || bits !== exp_frame(b)) begin n_fail++; $display("FAIL rand_tx: got ok=%b bits=%b expected %b", ok, bits, exp_frame(b)); end
      repeat (HP + 3) tick();
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [10:0] bits; bit ok;
    tx_data = 8'($urandom); tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    host_receive(1, bits, ok);
    reset = 1'b1;
    tick();
    n_tests++; if (!ok || PS2_CLK !== 1'b1 || PS2_DAT !== 1'b1) begin n_fail++; $display("FAIL rst_mid_lines: got ok=%b clk=%b dat=%b expected 1 1 1", ok, PS2_CLK, PS2_DAT); end
    n_tests++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got ready=%b busy=%b expected 1 0", tx_ready, busy); end
    reset = 1'b0;
    wait_fall(HOLD + 8 * HP, ok);
    n_tests++; if (ok) begin n_fail++; $display("FAIL rst_mid_residual: got clock edge=%b expected 0", ok); end
  endtask

  initial begin
    test_reset();
    test_rx_f4();
    test_tx_fa();
    test_rx_parity_err();
    test_bad_stop();
    test_abort();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
